// File: rtl/sec32_encode_pipe_if.sv
// rtl/sec32_encode_pipe_if.sv - handshake, codeword and injection bus for sec32_encode_pipe
//
// Purpose: groups the upstream word handshake, the downstream codeword
// handshake, the error-injection hook and the word counter of the SEC32
// check-bit generator.
// Ports (signals):
//   in_valid/in_ready/in_data        upstream 32-bit word handshake
//   out_valid/out_ready              downstream codeword handshake
//   out_data/out_chk/out_en          codeword fields and corrector enable
//   inj_arm/inj_pos/inj_pending      one-shot single-bit error injection
//   word_cnt                         count of codewords accepted downstream
// Modports: slave = the encoder, master = whoever drives and consumes it.
interface sec32_encode_pipe_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [7:0]       out_chk;
  logic             out_en;
  logic             inj_arm;
  logic [5:0]       inj_pos;
  logic             inj_pending;
  logic [CNT_W-1:0] word_cnt;

  modport slave (
    input  in_valid, in_data, out_ready, inj_arm, inj_pos,
    output in_ready, out_valid, out_data, out_chk, out_en, inj_pending, word_cnt
  );

  modport master (
    output in_valid, in_data, out_ready, inj_arm, inj_pos,
    input  in_ready, out_valid, out_data, out_chk, out_en, inj_pending, word_cnt
  );
endinterface

// File: rtl/sec32_encode_pipe.sv
// rtl/sec32_encode_pipe.sv - two-stage pipelined SEC32 check-bit generator with error injection
//
// Purpose: accepts 32-bit words, computes 8 check bits (chk[i] = ^(data & MASKi))
// and presents {data, chk, en} as one codeword to the downstream SEC corrector.
// A one-shot injection hook flips one codeword bit after the check bits are
// computed; word_cnt counts codewords accepted downstream.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   sec32_encode_pipe_if.slave (handshakes, codeword, injection, counter)
module sec32_encode_pipe #(
  parameter logic [31:0] MASK0 = 32'h1111_1111,
  parameter logic [31:0] MASK1 = 32'h2222_2222,
  parameter logic [31:0] MASK2 = 32'h4444_4444,
  parameter logic [31:0] MASK3 = 32'h8888_8888,
  parameter logic [31:0] MASK4 = 32'h0000_FFFF,
  parameter logic [31:0] MASK5 = 32'h00FF_00FF,
  parameter logic [31:0] MASK6 = 32'h0F0F_0F0F,
  parameter logic [31:0] MASK7 = 32'hFFFF_FFFF,
  parameter int          CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  sec32_encode_pipe_if.slave  bus
);

  typedef enum logic {INJ_IDLE, INJ_ARMED} inj_state_t;

  logic             s1_valid;
  logic [31:0]      s1_data;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [7:0]       out_chk_q;
  logic [CNT_W-1:0] cnt_q;

  inj_state_t       inj_state, inj_state_nx;
  logic [5:0]       inj_pos_q, inj_pos_nx;
  logic             inj_apply;

  logic             s2_ready;
  logic             s1_ready;
  logic             move;
  logic             out_xfer;
  logic             arm_ok;
  logic [39:0]      flip;
  logic [39:0]      codeword_nx;

  function automatic logic [7:0] calc_chk(input logic [31:0] d);
    logic [7:0] c;
    c[0] = ^(d & MASK0);
    c[1] = ^(d & MASK1);
    c[2] = ^(d & MASK2);
    c[3] = ^(d & MASK3);
    c[4] = ^(d & MASK4);
    c[5] = ^(d & MASK5);
    c[6] = ^(d & MASK6);
    c[7] = ^(d & MASK7);
    return c;
  endfunction

  // Ready chain: out_ready is the only signal that reaches in_ready combinationally.
  assign s2_ready = !out_valid_q || bus.out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign move     = s1_valid && s2_ready;
  assign out_xfer = out_valid_q && bus.out_ready;
  assign arm_ok   = bus.inj_arm && (bus.inj_pos < 6'd40);

  // Codeword layout {chk, data}: position 0..31 is data, 32..39 is chk[pos-32],
  // so a single shift covers both fields. The flip lands after chk is computed.
  assign flip        = inj_apply ? (40'd1 << inj_pos_q) : 40'd0;
  assign codeword_nx = {calc_chk(s1_data), s1_data} ^ flip;

  // Injection FSM: an arm in the same cycle as a move re-arms for the next word,
  // while the move consumes the previously latched position.
  always_comb begin
    inj_state_nx = inj_state;
    inj_pos_nx   = inj_pos_q;
    inj_apply    = 1'b0;
    case (inj_state)
      INJ_IDLE: begin
        if (arm_ok) begin
          inj_state_nx = INJ_ARMED;
          inj_pos_nx   = bus.inj_pos;
        end
      end
      INJ_ARMED: begin
        if (move) begin
          inj_apply    = 1'b1;
          inj_state_nx = INJ_IDLE;
        end
        if (arm_ok) begin
          inj_state_nx = INJ_ARMED;
          inj_pos_nx   = bus.inj_pos;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_state <= INJ_IDLE;
      inj_pos_q <= 6'd0;
    end else begin
      inj_state <= inj_state_nx;
      inj_pos_q <= inj_pos_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_data     <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_chk_q   <= 8'd0;
      cnt_q       <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data <= bus.in_data;
        end
      end
      if (s2_ready) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          {out_chk_q, out_data_q} <= codeword_nx;
        end
      end
      if (out_xfer) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready    = s1_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_en      = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_chk     = out_chk_q;
  assign bus.inj_pending = (inj_state == INJ_ARMED);
  assign bus.word_cnt    = cnt_q;

endmodule

// File: doc/sec32_encode_pipe.md
Name: sec32_encode_pipe

Overview:
- Pipelined check-bit generator for the 32-bit single-error-correcting datapath.
- Accepts 32-bit data words over a valid/ready handshake and computes 8 check bits.
- Emits data, check bits and enable as one codeword, which feeds the combinational SEC corrector directly downstream.
- Includes a one-shot error-injection hook and a word counter, so the corrector can be exercised in-system.

Parameters:
- MASK0, 32'h1111_1111, data bits XORed into chk[0]
- MASK1, 32'h2222_2222, data bits XORed into chk[1]
- MASK2, 32'h4444_4444, data bits XORed into chk[2]
- MASK3, 32'h8888_8888, data bits XORed into chk[3]
- MASK4, 32'h0000_FFFF, data bits XORed into chk[4]
- MASK5, 32'h00FF_00FF, data bits XORed into chk[5]
- MASK6, 32'h0F0F_0F0F, data bits XORed into chk[6]
- MASK7, 32'hFFFF_FFFF, data bits XORed into chk[7]
- CNT_W, 16, width of the accepted-word counter

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  32  data word; bit k is data position k
- out_valid  out  1  codeword valid
- out_ready  in  1  downstream accepts the codeword
- out_data  out  32  data field of the codeword (post-injection)
- out_chk  out  8  check-bit field (post-injection)
- out_en  out  1  corrector enable; equals out_valid
- inj_arm  in  1  one-cycle pulse that arms a single-bit flip
- inj_pos  in  6  bit to flip: 0..31 = data bit, 32..39 = chk bit (pos-32); 40..63 are ignored and do not arm
- inj_pending  out  1  armed, not yet applied
- word_cnt  out  CNT_W  count of codewords accepted downstream

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all of the following are 0 — S1/S2 valid flags, out_valid, out_en, out_data, out_chk, inj_pending, stored inj position, word_cnt. in_ready is combinational and reads 1 after reset.
- Pipeline stages:
  - S1 registers in_data when in_valid && in_ready.
  - S2 registers the S1 data together with chk[i] = ^(data & MASKi).
  - S2 drives the outputs. Latency from input handshake to out_valid is 2 cycles.
- Flow control (full throughput, no bubbles):
  - s2_ready = !out_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready.
- Stall: while out_valid && !out_ready, out_data, out_chk and out_en hold stable. S1 holds its word; in_ready drops once S1 is full.
- Output transfer: a transfer occurs on out_valid && out_ready. If S1 is valid in that cycle, S2 reloads in the same cycle; otherwise out_valid clears.
- Error injection state machine, states IDLE and ARMED:
  - IDLE -> ARMED on inj_arm with inj_pos < 40. The position is latched and inj_pending = 1.
  - ARMED -> IDLE when a word moves S1 -> S2. That word's selected bit is inverted after the check bits are computed, so the codeword carries a single-bit error. inj_pending clears on the same edge.
  - inj_arm while ARMED: the new position overwrites the old one; still one flip only.
  - inj_arm in the same cycle as the S1 -> S2 move: the old position applies to the moving word, and the new arm takes effect for the next word.
- word_cnt: increments on each output transfer and wraps modulo 2^CNT_W with no saturation.
- Reset mid-operation: in-flight words are discarded, the pending injection is cancelled, and the counter is cleared. No output is produced for words accepted before reset.
- No combinational path from in_valid/in_data to any output. The only combinational path from out_ready is to in_ready.

Test Plan:
- Basic encoding, out_ready = 1: send 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF. Expected out_chk is 8'h00, 8'hF1, 8'h88, 8'h00, each 2 cycles after its handshake. out_data equals input, out_en = 1, word_cnt = 4.
- Streaming: stream 100 back-to-back random words with out_ready = 1. Expect one output per cycle in order, in_ready constantly 1, and chk matching the reference XOR model.
- Backpressure: hold out_ready = 0 for 5 cycles with 3 words offered. Expect S2 and S1 full, in_ready = 0 after 2 accepts, and outputs stable. On release, the words drain in order with no loss or duplication.
- Injection: inj_arm with inj_pos = 0, then send 32'h0000_0001. Expect out_data = 0, out_chk = 8'hF1 and inj_pending 1 -> 0. The next word is unmodified. inj_pos = 39 on 32'h0 gives out_chk = 8'h80.
- Ignored position: inj_arm with inj_pos = 45. Expect inj_pending stays 0 and no word is altered.
- Reset during stall: 2 words held in the pipe, then assert rst for 1 cycle. Expect out_valid = 0, word_cnt = 0, inj_pending = 0, in_ready = 1 on the following cycle, and the discarded words never appear.
